// File: rtl/board_loader.sv
// board_loader: serial-to-parallel loader for the 8x8 Life board.
// Receives 64 data bits and 8 row-parity bits per frame. Only boards whose
// eight row checks all pass are published on board_out, through a
// valid/ready handshake.
module board_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic [63:0] board_out,
  output logic        board_valid,
  input  logic        board_ready,
  output logic        busy,
  output logic        frame_error
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DATA  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_VALID = 2'd3;

  logic [1:0]  state;
  logic [6:0]  count;
  logic [63:0] asm_reg;
  logic [7:0]  chk_reg;
  logic [7:0]  chk_next;

  // Even parity per row: check bit r must equal the XOR of row r.
  function automatic logic rows_ok(input logic [63:0] b, input logic [7:0] c);
    logic ok;
    ok = 1'b1;
    for (int r = 0; r < 8; r++) begin
      if ((^b[8*r +: 8]) != c[r]) ok = 1'b0;
    end
    return ok;
  endfunction

  // Check register as it will look once the bit arriving now is stored, so
  // the final comparison includes check bit 7.
  always_comb begin
    chk_next = chk_reg;
    chk_next[count[2:0]] = bit_in;
  end

  // Status outputs decode only the state register, never the inputs.
  assign busy        = (state == S_DATA) || (state == S_CHECK);
  assign board_valid = (state == S_VALID);

  // Frame sequencing, bit assembly and board publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      count       <= 7'd0;
      asm_reg     <= 64'h0;
      chk_reg     <= 8'h0;
      board_out   <= 64'h0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state <= S_DATA;
            count <= 7'd0;
          end
        end
        S_DATA: begin
          // A new strobe restarts the frame; its coincident bit is dropped.
          if (frame_start) begin
            count <= 7'd0;
          end else if (bit_valid) begin
            asm_reg[count[5:0]] <= bit_in;
            count               <= count + 7'd1;
            if (count == 7'd63) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (frame_start) begin
            state <= S_DATA;
            count <= 7'd0;
          end else if (bit_valid) begin
            // Indices 64..71 map onto check bits 0..7 via the low three bits.
            chk_reg <= chk_next;
            if (count == 7'd71) begin
              count <= 7'd0;
              if (rows_ok(asm_reg, chk_next)) begin
                board_out <= asm_reg;
                state     <= S_VALID;
              end else begin
                frame_error <= 1'b1;
                state       <= S_IDLE;
              end
            end else begin
              count <= count + 7'd1;
            end
          end
        end
        default: begin
          // S_VALID: hold the board until the consumer takes it; a strobe
          // in the handshake cycle starts the next frame immediately.
          if (board_ready) begin
            count <= 7'd0;
            state <= frame_start ? S_DATA : S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/board_loader.md
# board_loader

Serial-to-parallel loader for the 8x8 Game of Life board: it receives a framed bitstream of 64 cell bits plus 8 row-check bits and assembles the 64-bit board image. It checks every row and hands good boards to the cell-array state register through a valid/ready handshake. It is the write-side counterpart of the row-scanning LED display path, and replaces the hard-wired initial pattern with a runtime-loadable one.

## Interface
- No parameters; board geometry is fixed at 8 rows x 8 columns = 64 cells.
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- frame_start  input  1  one-cycle strobe that begins a new frame.
- bit_in  input  1  serial data bit, sampled only when bit_valid=1.
- bit_valid  input  1  qualifies bit_in this cycle.
- board_out  output  64  last accepted board; bit 8*r+c = row r, column c.
- board_valid  output  1  board_out holds a new, unconsumed board.
- board_ready  input  1  consumer accepts board_out this cycle.
- busy  output  1  a frame is in progress (DATA or CHECK state).
- frame_error  output  1  one-cycle pulse: the frame was discarded for a row-check mismatch.

## Operation
- Frame format: 64 data bits, then 8 check bits, 72 qualified bits in total.
  - Data bit k (k=0..63) maps to board bit k: row 0 first, column 0 first within a row.
  - Check bit r (r=0..7) = XOR of data bits 8r..8r+7 (even parity per row).
- Assembly happens in an internal 64-bit shift/assembly register and an 8-bit check register. board_out is written only from a good frame.
- A 7-bit counter holds the index of the next expected bit (0..71).
- FSM states:
  - IDLE: frame_start -> DATA with count=0. bit_valid is ignored.
  - DATA: each bit_valid stores bit_in at index count, then count+1. When bit 63 is accepted -> CHECK.
  - CHECK: each bit_valid stores a check bit. When check bit 7 is accepted, compare all 8 rows:
    - all rows match -> copy the assembly register to board_out and go to VALID;
    - any mismatch -> pulse frame_error and go to IDLE; board_out is unchanged.
  - VALID: board_valid=1. board_valid & board_ready at a posedge completes the transfer -> IDLE.
- Rules for boundary and simultaneous events:
  - frame_start in DATA or CHECK aborts the partial frame and restarts at count=0. No frame_error pulse.
  - frame_start and bit_valid in the same cycle: frame_start wins and that bit is discarded.
  - In VALID, frame_start and bit_valid are ignored, except in the cycle the handshake completes. A frame_start in that cycle is honored: next state is DATA, count=0.
  - board_ready in any state other than VALID has no effect.
  - The counter never wraps. The transition out of CHECK at index 71 is the only exit.
- Reset mid-frame discards all partial data and returns to IDLE.

## Timing
- Reset values:
  - board_out = 64'h0, board_valid = 0, busy = 0, frame_error = 0.
  - state = IDLE, count = 0, assembly and check registers = 0.
- All outputs are registered; none depend combinationally on inputs.
- frame_start sampled at edge T -> busy=1 from T+1.
- Last check bit sampled at edge N:
  - good frame: board_valid=1 and new board_out from N+1, busy=0 from N+1;
  - bad frame: frame_error=1 for exactly cycle N+1 only, busy=0 from N+1.
- board_out stays stable while board_valid=1.
- Handshake at edge H: board_valid=0 from H+1. board_out keeps its value until the next good frame.
- Minimum frame length is 73 cycles (strobe plus 72 bits). Gaps in bit_valid are allowed without limit.
- Back-to-back throughput: one board per 73 cycles, provided board_ready is held high.

## Test plan
- Reset, then a good frame loading the blinker 64'h0000_0000_001C_0000 (check bits 00000100b) with board_ready=1 -> board_valid high for one cycle at N+1, board_out=64'h0000_0000_001C_0000, frame_error stays 0.
- Same frame with check bit 2 flipped -> frame_error pulses once at N+1, board_valid stays 0, board_out remains 64'h0.
- Good frame 64'hFFFF_FFFF_FFFF_FFFF (all check bits 0) with board_ready=0 for 10 cycles -> board_valid holds for 10 cycles and the board is unchanged. Bits and a frame_start sent meanwhile are ignored. Raising board_ready clears board_valid on the next cycle.
- Random bit_valid gaps, and frame_start after 30 bits followed by a full good frame 64'h8000_0000_0000_0001 -> only the second frame is delivered, with no frame_error.
- Assert rst at data bit 40 of a frame -> all outputs return to reset values immediately. A following good frame loads correctly.
- frame_start in the same cycle as the board_ready handshake, followed by a good frame -> two consecutive boards delivered with no lost bits.
